// File: rtl/cascade_stage_evaluator.sv
// Cascade stage evaluator: walks up to NUM_STAGES classifier stages, summing signed
// haar responses per stage against a threshold and exiting on the first failing stage.
module cascade_stage_evaluator #(
  parameter int DATA_WIDTH                = 8,
  parameter int ACC_WIDTH                 = 16,
  parameter int NUM_STAGES                = 3,
  parameter int MAX_CLASSIFIERS_PER_STAGE = 50,
  localparam int STAGE_W = $clog2(NUM_STAGES + 1),
  localparam int CLS_W   = $clog2(MAX_CLASSIFIERS_PER_STAGE + 1)
) (
  input  logic                         clk_fpga,
  input  logic                         reset_fpga,
  input  logic                         i_start,
  input  logic [STAGE_W-1:0]           i_num_stages,
  input  logic                         i_abort,
  output logic [STAGE_W-1:0]           o_cfg_stage,
  input  logic [CLS_W-1:0]             i_cfg_num_classifiers,
  input  logic signed [ACC_WIDTH-1:0]  i_cfg_threshold,
  output logic                         o_req_valid,
  output logic [STAGE_W-1:0]           o_req_stage,
  output logic [CLS_W-1:0]             o_req_index,
  input  logic                         i_req_ready,
  input  logic                         i_haar_valid,
  input  logic signed [DATA_WIDTH-1:0] i_haar_value,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_iscandidate,
  output logic [STAGE_W-1:0]           o_reject_stage
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_COMPARE, S_DONE} state_e;

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // Assert is asynchronous; release is retimed so the first start lands on the second edge.
  logic rst_n_q;
  always_ff @(posedge clk_fpga or negedge reset_fpga)
    if (!reset_fpga) rst_n_q <= 1'b0;
    else             rst_n_q <= 1'b1;

  state_e                       state_q, state_d;
  logic [STAGE_W-1:0]           stage_q, stage_d, nstg_q, nstg_d, rej_q, rej_d;
  logic [CLS_W-1:0]             cnt_q, cnt_d, req_cnt_q, req_cnt_d, rsp_cnt_q, rsp_cnt_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d, thr_q, thr_d, acc_sat;
  logic                         cand_q, cand_d;
  logic [STAGE_W-1:0]           nstg_in;
  logic [CLS_W-1:0]             cnt_in;
  logic [ACC_WIDTH:0]           sum;
  logic                         req_fire, rsp_take;

  always_comb begin
    nstg_in = i_num_stages;
    if (i_num_stages == '0)                         nstg_in = STAGE_W'(1);
    else if (i_num_stages > STAGE_W'(NUM_STAGES))   nstg_in = STAGE_W'(NUM_STAGES);
    cnt_in = i_cfg_num_classifiers;
    if (i_cfg_num_classifiers > CLS_W'(MAX_CLASSIFIERS_PER_STAGE))
      cnt_in = CLS_W'(MAX_CLASSIFIERS_PER_STAGE);
  end

  // One guard bit: a disagreement between the top two bits means the add overflowed.
  always_comb begin
    sum = {acc_q[ACC_WIDTH-1], acc_q}
        + {{(ACC_WIDTH+1-DATA_WIDTH){i_haar_value[DATA_WIDTH-1]}}, i_haar_value};
    acc_sat = sum[ACC_WIDTH-1:0];
    if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) acc_sat = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
  end

  assign req_fire = (state_q == S_RUN) && (req_cnt_q < cnt_q) && i_req_ready;
  assign rsp_take = (state_q == S_RUN) && (rsp_cnt_q < cnt_q) && i_haar_valid;

  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    nstg_d    = nstg_q;
    cnt_d     = cnt_q;
    thr_d     = thr_q;
    req_cnt_d = req_cnt_q;
    rsp_cnt_d = rsp_cnt_q;
    acc_d     = acc_q;
    cand_d    = cand_q;
    rej_d     = rej_q;
    case (state_q)
      S_IDLE: if (i_start) begin
        nstg_d  = nstg_in;
        stage_d = '0;
        acc_d   = '0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        cnt_d     = cnt_in;
        thr_d     = i_cfg_threshold;
        req_cnt_d = '0;
        rsp_cnt_d = '0;
        acc_d     = '0;
        state_d   = (cnt_in == '0) ? S_COMPARE : S_RUN;
      end
      S_RUN: begin
        if (req_fire) req_cnt_d = req_cnt_q + CLS_W'(1);
        if (rsp_take) begin
          acc_d     = acc_sat;
          rsp_cnt_d = rsp_cnt_q + CLS_W'(1);
        end
        // Leave as soon as the final response lands so COMPARE sees the full sum.
        if (rsp_cnt_d == cnt_q) state_d = S_COMPARE;
      end
      S_COMPARE: begin
        if (acc_q > thr_q) begin
          if ((stage_q + STAGE_W'(1)) < nstg_q) begin
            stage_d = stage_q + STAGE_W'(1);
            state_d = S_LOAD;
          end else begin
            cand_d  = 1'b1;
            rej_d   = nstg_q;
            state_d = S_DONE;
          end
        end else begin
          cand_d  = 1'b0;
          rej_d   = stage_q;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (i_abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cand_d  = cand_q;
      rej_d   = rej_q;
    end
  end

  always_ff @(posedge clk_fpga or negedge rst_n_q) begin
    if (!rst_n_q) begin
      state_q   <= S_IDLE;
      stage_q   <= '0;
      nstg_q    <= '0;
      cnt_q     <= '0;
      thr_q     <= '0;
      req_cnt_q <= '0;
      rsp_cnt_q <= '0;
      acc_q     <= '0;
      cand_q    <= 1'b0;
      rej_q     <= '0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      nstg_q    <= nstg_d;
      cnt_q     <= cnt_d;
      thr_q     <= thr_d;
      req_cnt_q <= req_cnt_d;
      rsp_cnt_q <= rsp_cnt_d;
      acc_q     <= acc_d;
      cand_q    <= cand_d;
      rej_q     <= rej_d;
    end
  end

  assign o_cfg_stage    = stage_q;
  assign o_req_valid    = (state_q == S_RUN) && (req_cnt_q < cnt_q);
  assign o_req_stage    = stage_q;
  assign o_req_index    = req_cnt_q;
  assign o_busy         = (state_q != S_IDLE);
  assign o_done         = (state_q == S_DONE);
  assign o_iscandidate  = cand_q;
  assign o_reject_stage = rej_q;

endmodule

// File: tb/tb_cascade_stage_evaluator.sv
// Randomized bench for cascade_stage_evaluator: a table-driven classifier responder
// with random latency/backpressure, checked against a plain-arithmetic cascade model.
module tb_cascade_stage_evaluator;
  localparam int DW = 8, AW = 10, NS = 3, MC = 50, SW = 2, CW = 6;
  localparam int AMAX = 511, AMIN = -512;

  logic                 clk_fpga = 1'b0, reset_fpga = 1'b0;
  logic                 i_start = 1'b0, i_abort = 1'b0;
  logic [SW-1:0]        i_num_stages = '0;
  logic [SW-1:0]        o_cfg_stage;
  logic [CW-1:0]        i_cfg_num_classifiers;
  logic signed [AW-1:0] i_cfg_threshold;
  logic                 o_req_valid, i_req_ready = 1'b0;
  logic [SW-1:0]        o_req_stage;
  logic [CW-1:0]        o_req_index;
  logic                 i_haar_valid = 1'b0;
  logic signed [DW-1:0] i_haar_value = '0;
  logic                 o_busy, o_done, o_iscandidate;
  logic [SW-1:0]        o_reject_stage;

  logic [CW-1:0]        cfg_cnt [4];
  logic signed [AW-1:0] cfg_thr [4];
  logic signed [DW-1:0] vals [4][64];

  assign i_cfg_num_classifiers = cfg_cnt[o_cfg_stage];
  assign i_cfg_threshold       = cfg_thr[o_cfg_stage];

  cascade_stage_evaluator #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .NUM_STAGES(NS),
                            .MAX_CLASSIFIERS_PER_STAGE(MC)) dut (
    .clk_fpga(clk_fpga), .reset_fpga(reset_fpga), .i_start(i_start),
    .i_num_stages(i_num_stages), .i_abort(i_abort), .o_cfg_stage(o_cfg_stage),
    .i_cfg_num_classifiers(i_cfg_num_classifiers), .i_cfg_threshold(i_cfg_threshold),
    .o_req_valid(o_req_valid), .o_req_stage(o_req_stage), .o_req_index(o_req_index),
    .i_req_ready(i_req_ready), .i_haar_valid(i_haar_valid), .i_haar_value(i_haar_value),
    .o_busy(o_busy), .o_done(o_done), .o_iscandidate(o_iscandidate),
    .o_reject_stage(o_reject_stage));

  always #5 clk_fpga = ~clk_fpga;

  int checks = 0, failures = 0;
  int cyc = 0, done_cnt = 0, windows = 0, req_s2 = 0, xfers = 0, valid_cyc = 0;
  bit zero_wait = 1'b0, stall_prev = 1'b0;
  logic [SW-1:0] stg_prev;
  logic [CW-1:0] idx_prev;
  int q_due[$];
  int q_val[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  function automatic void model(input int ns_raw, input bit zw, output bit cand,
                                output int rej, output int lat);
    int ns, cnt, acc;
    bit lat_ok;
    ns = (ns_raw == 0) ? 1 : ((ns_raw > NS) ? NS : ns_raw);
    cand = 1'b1; rej = ns; lat = 1; lat_ok = zw;
    for (int s = 0; s < ns; s++) begin
      cnt = (int'(cfg_cnt[s]) > MC) ? MC : int'(cfg_cnt[s]);
      if (cnt == 0) lat_ok = 1'b0;
      lat += cnt + 3;
      acc = 0;
      for (int i = 0; i < cnt; i++) begin
        acc += int'(vals[s][i]);
        if (acc > AMAX) acc = AMAX;
        if (acc < AMIN) acc = AMIN;
      end
      if (acc <= int'(cfg_thr[s])) begin
        cand = 1'b0; rej = s;
        break;
      end
    end
    if (!lat_ok) lat = 0;
  endfunction

  // One bench cycle: sample at the falling edge, then play the classifier responder.
  task automatic step();
    @(negedge clk_fpga);
    cyc++;
    if (o_done) done_cnt++;
    if (o_req_valid) valid_cyc++;
    if (o_req_valid && o_req_stage == 2'd2) req_s2++;
    if (stall_prev)
      chk("stall_hold", {23'd0, o_req_valid, o_req_stage, o_req_index}, {23'd0, 1'b1, stg_prev, idx_prev});
    i_req_ready = zero_wait ? 1'b1 : ($urandom_range(0, 3) != 0);
    if (q_due.size() > 0 && q_due[0] <= cyc) begin
      i_haar_valid = 1'b1;
      i_haar_value = DW'(q_val.pop_front());
      void'(q_due.pop_front());
    end else begin
      i_haar_valid = !o_busy && ($urandom_range(0, 3) == 0);
      i_haar_value = DW'($urandom);
    end
    if (o_req_valid && i_req_ready) begin
      xfers++;
      q_due.push_back(cyc + 1 + (zero_wait ? 0 : int'($urandom_range(0, 3))));
      q_val.push_back(int'(vals[o_req_stage][o_req_index]));
    end
    stall_prev = o_req_valid && !i_req_ready;
    stg_prev = o_req_stage;
    idx_prev = o_req_index;
  endtask

  task automatic flush();
    q_due.delete(); q_val.delete();
    stall_prev = 1'b0;
    i_haar_valid = 1'b0;
  endtask

  task automatic launch(input int ns, input bit zw, output int c0);
    zero_wait = zw;
    i_num_stages = SW'(ns);
    i_start = 1'b1;
    c0 = cyc;
    step();
    i_start = 1'b0;
  endtask

  task automatic finish_window(input string tag, input int c0, input bit ec, input int er, input int lat);
    bit got = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if (o_done) begin got = 1'b1; break; end
      i_start = o_busy && ($urandom_range(0, 3) == 0);
      i_num_stages = SW'($urandom_range(0, 3));
      step();
    end
    i_start = 1'b0;
    chk({tag, "_done"}, 32'(got), 32'd1);
    if (got) begin
      windows++;
      chk({tag, "_cand"}, 32'(o_iscandidate), 32'(ec));
      chk({tag, "_rej"}, 32'(o_reject_stage), 32'(er));
      if (lat > 0) chk({tag, "_lat"}, 32'(cyc - c0), 32'(lat));
      step();
      chk({tag, "_pulse"}, {30'd0, o_done, o_busy}, 32'd0);
      chk({tag, "_hold"}, {29'd0, o_iscandidate, o_reject_stage}, {29'd0, ec, 2'(er)});
    end
    flush();
  endtask

  task automatic set_stage(input int s, input int cnt, input int thr, input int v);
    cfg_cnt[s] = CW'(cnt);
    cfg_thr[s] = AW'(thr);
    for (int i = 0; i < 64; i++) vals[s][i] = DW'(v);
  endtask

  task automatic wait_valid(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (o_req_valid) begin seen = 1'b1; break; end
      step();
    end
    chk({tag, "_run"}, 32'(seen), 32'd1);
  endtask

  initial begin
    int c0, er, lat, d0, rs2, x0;
    bit ec;
    logic [SW-1:0] rej_keep;
    logic cand_keep;
    for (int s = 0; s < 4; s++) set_stage(s, 0, 0, 0);

    // reset state, then first start honoured only on the second edge after release
    repeat (3) step();
    chk("rst_outs", {26'd0, o_busy, o_done, o_req_valid, o_iscandidate, o_reject_stage}, 32'd0);
    set_stage(0, 3, 17, 0);
    vals[0][0] = 8'sd5; vals[0][1] = 8'sd6; vals[0][2] = 8'sd7;
    zero_wait = 1'b1;
    i_num_stages = 2'd1;
    i_start = 1'b1;
    reset_fpga = 1'b1;
    step();
    chk("rst_sync_edge1_busy", 32'(o_busy), 32'd0);
    step();
    chk("rst_sync_edge2_busy", 32'(o_busy), 32'd1);
    i_start = 1'b0;
    finish_window("pass_17", cyc - 1, 1'b1, 1, 7);

    set_stage(0, 3, 18, 0);
    vals[0][0] = 8'sd5; vals[0][1] = 8'sd6; vals[0][2] = 8'sd7;
    launch(1, 1'b1, c0);
    finish_window("fail_18", c0, 1'b0, 0, 7);

    // early exit on stage 1: stage 2 must never be requested
    set_stage(0, 2, 0, 10); set_stage(1, 2, 0, -4); set_stage(2, 5, -100, 1);
    rs2 = req_s2;
    launch(3, 1'b0, c0);
    finish_window("early_exit", c0, 1'b0, 1, 0);
    chk("early_exit_no_s2", 32'(req_s2 - rs2), 32'd0);

    // saturation in a 10-bit accumulator
    set_stage(0, 10, 510, 127);
    launch(1, 1'b0, c0);
    finish_window("sat_hi_510", c0, 1'b1, 1, 0);
    set_stage(0, 10, 511, 127);
    launch(1, 1'b1, c0);
    finish_window("sat_hi_511", c0, 1'b0, 0, 1 + 13);
    set_stage(0, 10, -512, -128);
    launch(1, 1'b0, c0);
    finish_window("sat_lo", c0, 1'b0, 0, 0);

    // empty stage, count clamp, stage-count 0 treated as 1
    set_stage(0, 0, -1, 0);
    d0 = valid_cyc;
    launch(1, 1'b0, c0);
    finish_window("cnt0_pass", c0, 1'b1, 1, 0);
    chk("cnt0_no_req", 32'(valid_cyc - d0), 32'd0);
    set_stage(0, 0, 0, 0);
    launch(1, 1'b0, c0);
    finish_window("cnt0_fail", c0, 1'b0, 0, 0);
    set_stage(0, 60, 49, 1);
    x0 = xfers;
    launch(1, 1'b0, c0);
    finish_window("clamp_pass", c0, 1'b1, 1, 0);
    chk("clamp_reqs", 32'(xfers - x0), 32'd50);
    set_stage(0, 2, 0, 3); set_stage(1, 2, 100, 3);
    launch(0, 1'b0, c0);
    finish_window("ns0", c0, 1'b1, 1, 0);

    // abort mid-RUN: back to IDLE, no done, results untouched
    set_stage(0, 20, 0, 1);
    cand_keep = o_iscandidate; rej_keep = o_reject_stage;
    launch(1, 1'b0, c0);
    wait_valid("abort");
    step(); step();
    d0 = done_cnt;
    i_abort = 1'b1;
    flush();
    step();
    chk("abort_idle", {30'd0, o_busy, o_req_valid}, 32'd0);
    i_abort = 1'b0;
    flush();
    repeat (4) step();
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_results", {29'd0, o_iscandidate, o_reject_stage}, {29'd0, cand_keep, rej_keep});
    set_stage(0, 4, 8, 3);
    i_abort = 1'b1;
    launch(1, 1'b1, c0);
    i_abort = 1'b0;
    finish_window("start_wins", c0, 1'b1, 1, 8);

    // reset pulse mid-RUN, then a clean restart
    set_stage(0, 20, 0, 1);
    launch(1, 1'b0, c0);
    wait_valid("rstmid");
    step();
    #2 reset_fpga = 1'b0;
    #1 chk("rstmid_async", {26'd0, o_busy, o_done, o_req_valid, o_iscandidate, o_reject_stage}, 32'd0);
    flush();
    step(); step();
    reset_fpga = 1'b1;
    flush();
    step(); step();
    flush();
    set_stage(0, 3, 17, 0);
    vals[0][0] = 8'sd5; vals[0][1] = 8'sd6; vals[0][2] = 8'sd7;
    launch(1, 1'b1, c0);
    finish_window("rstmid_restart", c0, 1'b1, 1, 7);

    // randomized windows against the model
    for (int n = 0; n < 40; n++) begin
      int ns;
      bit zw;
      for (int s = 0; s < NS; s++) begin
        cfg_cnt[s] = ($urandom_range(0, 9) == 0) ? CW'(55) : CW'($urandom_range(0, 12));
        cfg_thr[s] = AW'(int'($urandom_range(0, 60)) - 20);
        for (int i = 0; i < 64; i++)
          vals[s][i] = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'(int'($urandom_range(0, 60)) - 20);
      end
      ns = $urandom_range(0, 3);
      zw = ($urandom_range(0, 3) == 0);
      model(ns, zw, ec, er, lat);
      launch(ns, zw, c0);
      finish_window("rand", c0, ec, er, lat);
      repeat ($urandom_range(0, 3)) step();
    end

    chk("done_pulses", 32'(done_cnt), 32'(windows));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
